// File: rtl/vslc_scan_sequencer.sv
// Program store and scan-cycle controller for the VSLC executor: loads a byte program,
// then replays it one strobed byte per step with a stable ui_in snapshot per scan.
module vslc_scan_sequencer #(
    parameter int PROG_DEPTH = 32,
    parameter int ADDR_W     = 5,
    parameter int GAP_CYCLES = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load_start,
    input  logic              i_load_valid,
    input  logic [7:0]        i_load_data,
    output logic              o_load_ready,
    input  logic              i_run,
    output logic [7:0]        o_instr,
    output logic              o_instr_ready,
    input  logic [7:0]        i_ui_in,
    output logic [7:0]        o_ui_snap,
    output logic [7:0]        o_ui_snap_prev,
    output logic [ADDR_W-1:0] o_pc,
    output logic [ADDR_W:0]   o_prog_len,
    output logic              o_busy,
    output logic              o_scan_done,
    output logic              o_err_empty
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [ADDR_W:0]  DEPTH    = (ADDR_W + 1)'(PROG_DEPTH);

    typedef enum logic [1:0] {IDLE, SNAP, STROBE, GAP} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [7:0]         r_mem [PROG_DEPTH];
    logic [ADDR_W:0]    r_prog_len;
    logic [ADDR_W-1:0]  r_pc;
    logic [7:0]         r_instr;
    logic [7:0]         r_ui_snap;
    logic [7:0]         r_ui_snap_prev;
    logic               r_scan_done;
    logic               r_err_empty;
    logic [GAP_W-1:0]   r_gap_cnt;

    logic               w_gap_end;
    logic               w_last;
    logic               w_accept;
    logic [ADDR_W-1:0]  w_pc_next;

    assign w_gap_end = (r_state == GAP) && (r_gap_cnt == GAP_LAST);
    assign w_last    = ({1'b0, r_pc} == (r_prog_len - 1'b1));
    assign w_pc_next = r_pc + ADDR_W'(1);
    // load_start wins over a same-cycle byte, which is dropped
    assign w_accept  = (r_state == IDLE) && !i_load_start && i_load_valid && o_load_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (i_run && (r_prog_len != '0)) w_next = SNAP;
            SNAP:    w_next = STROBE;
            STROBE:  w_next = GAP;
            GAP: begin
                if (w_gap_end) begin
                    if (!w_last)    w_next = STROBE;
                    else if (i_run) w_next = SNAP;
                    else            w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        o_load_ready  = (r_state == IDLE) && (r_prog_len < DEPTH);
        o_instr_ready = (r_state == STROBE);
        o_busy        = (r_state != IDLE);
    end

    // Program memory is deliberately left out of reset
    always_ff @(posedge i_clk) begin
        if (w_accept) r_mem[r_prog_len[ADDR_W-1:0]] <= i_load_data;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_prog_len     <= '0;
            r_pc           <= '0;
            r_instr        <= 8'h00;
            r_ui_snap      <= 8'h00;
            r_ui_snap_prev <= 8'h00;
            r_scan_done    <= 1'b0;
            r_err_empty    <= 1'b0;
            r_gap_cnt      <= '0;
        end else begin
            r_scan_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_load_start) begin
                        r_prog_len  <= '0;
                        r_err_empty <= 1'b0;
                    end else begin
                        if (w_accept) r_prog_len <= r_prog_len + 1'b1;
                        if (i_run && (r_prog_len == '0)) r_err_empty <= 1'b1;
                    end
                end
                SNAP: begin
                    r_ui_snap_prev <= r_ui_snap;
                    r_ui_snap      <= i_ui_in;
                    r_pc           <= '0;
                    r_instr        <= r_mem[0];
                end
                STROBE: r_gap_cnt <= '0;
                GAP: begin
                    if (!w_gap_end) begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end else if (w_last) begin
                        r_pc        <= '0;
                        r_scan_done <= 1'b1;
                    end else begin
                        r_pc    <= w_pc_next;
                        r_instr <= r_mem[w_pc_next];
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_instr        = r_instr;
    assign o_ui_snap      = r_ui_snap;
    assign o_ui_snap_prev = r_ui_snap_prev;
    assign o_pc           = r_pc;
    assign o_prog_len     = r_prog_len;
    assign o_scan_done    = r_scan_done;
    assign o_err_empty    = r_err_empty;

endmodule

// File: tb/tb_vslc_scan_sequencer.sv
// Directed bench for vslc_scan_sequencer: load/run/stop/reset sequences with
// hand-computed expectations (GAP_CYCLES=2, so a byte step is 3 cycles).
module tb_vslc_scan_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       load_start;
    logic       load_valid;
    logic [7:0] load_data;
    logic       load_ready;
    logic       run;
    logic [7:0] instr;
    logic       instr_ready;
    logic [7:0] ui_in;
    logic [7:0] ui_snap;
    logic [7:0] ui_snap_prev;
    logic [4:0] pc;
    logic [5:0] prog_len;
    logic       busy;
    logic       scan_done;
    logic       err_empty;

    int vectors = 0;
    int miscompares = 0;

    vslc_scan_sequencer #(.PROG_DEPTH(32), .ADDR_W(5), .GAP_CYCLES(2)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_load_start   (load_start),
        .i_load_valid   (load_valid),
        .i_load_data    (load_data),
        .o_load_ready   (load_ready),
        .i_run          (run),
        .o_instr        (instr),
        .o_instr_ready  (instr_ready),
        .i_ui_in        (ui_in),
        .o_ui_snap      (ui_snap),
        .o_ui_snap_prev (ui_snap_prev),
        .o_pc           (pc),
        .o_prog_len     (prog_len),
        .o_busy         (busy),
        .o_scan_done    (scan_done),
        .o_err_empty    (err_empty)
    );

    always #5 clk = ~clk;

    // Advance n clock edges; inputs and samples both sit 1 time unit after the edge
    task automatic applyStimulus(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        rst = 1'b1; load_start = 1'b0; load_valid = 1'b0; load_data = 8'h00;
        run = 1'b0; ui_in = 8'h00;
        applyStimulus(2);
        rst = 1'b0;
        checkOutput("rst_load_ready", 32'(load_ready), 32'd1);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_instr_ready", 32'(instr_ready), 32'd0);
        checkOutput("rst_pc", 32'(pc), 32'd0);
        checkOutput("rst_prog_len", 32'(prog_len), 32'd0);
        checkOutput("rst_instr", 32'(instr), 32'd0);
        checkOutput("rst_err_empty", 32'(err_empty), 32'd0);
        checkOutput("rst_scan_done", 32'(scan_done), 32'd0);

        load_valid = 1'b1;
        load_data = 8'h00; applyStimulus(1);
        load_data = 8'h90; applyStimulus(1);
        load_data = 8'h18; applyStimulus(1);
        load_valid = 1'b0;
        checkOutput("load3_prog_len", 32'(prog_len), 32'd3);

        ui_in = 8'h01;
        run = 1'b1;
        applyStimulus(1);
        checkOutput("snap_busy", 32'(busy), 32'd1);
        checkOutput("snap_no_strobe", 32'(instr_ready), 32'd0);
        applyStimulus(1);
        checkOutput("s1_b0_strobe", 32'(instr_ready), 32'd1);
        checkOutput("s1_b0_instr", 32'(instr), 32'h00);
        checkOutput("s1_ui_snap", 32'(ui_snap), 32'h01);
        applyStimulus(1);
        checkOutput("s1_gap_low", 32'(instr_ready), 32'd0);
        applyStimulus(2);
        checkOutput("s1_b1_strobe", 32'(instr_ready), 32'd1);
        checkOutput("s1_b1_instr", 32'(instr), 32'h90);
        checkOutput("s1_b1_pc", 32'(pc), 32'd1);
        applyStimulus(2);
        checkOutput("s1_gap_hold", 32'(instr), 32'h90);
        applyStimulus(1);
        checkOutput("s1_b2_instr", 32'(instr), 32'h18);
        checkOutput("s1_b2_pc", 32'(pc), 32'd2);
        ui_in = 8'h03;
        applyStimulus(2);
        checkOutput("s1_no_done_early", 32'(scan_done), 32'd0);
        applyStimulus(1);
        checkOutput("s1_scan_done", 32'(scan_done), 32'd1);
        checkOutput("s1_done_pc", 32'(pc), 32'd0);
        applyStimulus(1);
        checkOutput("s2_done_clear", 32'(scan_done), 32'd0);
        checkOutput("s2_b0_instr", 32'(instr), 32'h00);
        checkOutput("s2_ui_snap", 32'(ui_snap), 32'h03);
        checkOutput("s2_ui_snap_prev", 32'(ui_snap_prev), 32'h01);
        ui_in = 8'hFF;
        applyStimulus(3);
        checkOutput("s2_snap_stable", 32'(ui_snap), 32'h03);
        checkOutput("s2_b1_instr", 32'(instr), 32'h90);
        run = 1'b0;
        applyStimulus(3);
        checkOutput("stop_b2_strobe", 32'(instr_ready), 32'd1);
        checkOutput("stop_b2_instr", 32'(instr), 32'h18);
        applyStimulus(3);
        checkOutput("stop_scan_done", 32'(scan_done), 32'd1);
        checkOutput("stop_busy", 32'(busy), 32'd0);
        applyStimulus(1);
        checkOutput("stop_idle_strobe", 32'(instr_ready), 32'd0);
        checkOutput("stop_snap_kept", 32'(ui_snap), 32'h03);

        load_start = 1'b1; applyStimulus(1); load_start = 1'b0;
        checkOutput("clr_prog_len", 32'(prog_len), 32'd0);
        run = 1'b1;
        applyStimulus(1);
        checkOutput("empty_err", 32'(err_empty), 32'd1);
        applyStimulus(2);
        checkOutput("empty_busy", 32'(busy), 32'd0);
        checkOutput("empty_no_strobe", 32'(instr_ready), 32'd0);
        run = 1'b0;
        load_start = 1'b1; applyStimulus(1); load_start = 1'b0;
        checkOutput("empty_err_clear", 32'(err_empty), 32'd0);

        load_valid = 1'b1;
        load_data = 8'h00; applyStimulus(1);
        load_data = 8'h90; applyStimulus(1);
        load_data = 8'h18; applyStimulus(1);
        load_valid = 1'b0;
        run = 1'b1;
        applyStimulus(5);
        checkOutput("rr_b1_instr", 32'(instr), 32'h90);
        load_valid = 1'b1; load_data = 8'h55;
        checkOutput("busy_no_ready", 32'(load_ready), 32'd0);
        applyStimulus(1);
        load_valid = 1'b0;
        checkOutput("busy_no_accept", 32'(prog_len), 32'd3);
        applyStimulus(3);
        checkOutput("rr_b2_pc", 32'(pc), 32'd2);
        rst = 1'b1;
        applyStimulus(1);
        rst = 1'b0;
        run = 1'b0;
        checkOutput("midrst_strobe", 32'(instr_ready), 32'd0);
        checkOutput("midrst_pc", 32'(pc), 32'd0);
        checkOutput("midrst_prog_len", 32'(prog_len), 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);

        load_valid = 1'b1;
        for (int i = 0; i < 34; i++) begin
            load_data = 8'(i);
            if (i == 32) checkOutput("full_ready_drop", 32'(load_ready), 32'd0);
            applyStimulus(1);
        end
        load_valid = 1'b0;
        checkOutput("full_prog_len", 32'(prog_len), 32'd32);
        run = 1'b1;
        applyStimulus(95);
        checkOutput("full_last_pc", 32'(pc), 32'd31);
        checkOutput("full_last_instr", 32'(instr), 32'h1F);
        checkOutput("full_last_strobe", 32'(instr_ready), 32'd1);
        applyStimulus(3);
        checkOutput("full_wrap_done", 32'(scan_done), 32'd1);
        checkOutput("full_wrap_pc", 32'(pc), 32'd0);
        run = 1'b0;
        applyStimulus(1);
        checkOutput("full_rescan_instr", 32'(instr), 32'h00);
        begin
            int budget = 0;
            while (busy && budget < 200) begin
                applyStimulus(1);
                budget++;
            end
            checkOutput("full_stop_idle", 32'(busy), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
